jtag_ir_param: RTL

//  Parametrised JTAG instruction register driven by the TAP state code. Captures a fixed

---
 rtl/jtag_ir_param_if.sv | 29 ++
 rtl/jtag_ir_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_ir_param_if.sv
// Signal bundle between the TAP controller side and the parametrised JTAG instruction register.
// master = TAP/controller side, slave = instruction register.
interface jtag_ir_param_if #(
    parameter int IR_LEN    = 4,
    parameter int NUM_INSTR = 6
);
    localparam int ST_W = (IR_LEN > 2) ? IR_LEN - 2 : 1;

    logic [3:0]           state;
    logic                 tdi;
    logic [ST_W-1:0]      status_i;
    logic                 tdo;
    logic                 tdo_en;
    logic [NUM_INSTR-1:0] instr;
    logic [IR_LEN-1:0]    ir_value;
    logic                 unk_op;
    logic                 len_err;
    logic                 par_err;

    modport master (
        output state, tdi, status_i,
        input  tdo, tdo_en, instr, ir_value, unk_op, len_err, par_err
    );

    modport slave (
        input  state, tdi, status_i,
        output tdo, tdo_en, instr, ir_value, unk_op, len_err, par_err
    );
endinterface

// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: capture/shift/update driven by the TAP state code,
// table-based one-hot opcode decode. Optional parity bit enabled by the IR_PARITY_EN macro.
module jtag_ir_param #(
    parameter int                          IR_LEN    = 4,
    parameter int                          NUM_INSTR = 6,
    parameter logic [NUM_INSTR*IR_LEN-1:0] OPCODES   = {4'b0110, 4'b0101, 4'b0000,
                                                        4'b0010, 4'b0001, 4'b1111},
    parameter int                          RST_INSTR = 0
) (
    input logic            clk,
    input logic            reset,
    jtag_ir_param_if.slave bus
);

    // IEEE 1149.1 TAP state encodings
    localparam logic [3:0] exit2_dr_c         = 4'h0;
    localparam logic [3:0] exit1_dr_c         = 4'h1;
    localparam logic [3:0] shift_dr_c         = 4'h2;
    localparam logic [3:0] pause_dr_c         = 4'h3;
    localparam logic [3:0] select_ir_c        = 4'h4;
    localparam logic [3:0] update_dr_c        = 4'h5;
    localparam logic [3:0] capture_dr_c       = 4'h6;
    localparam logic [3:0] select_dr_c        = 4'h7;
    localparam logic [3:0] exit2_ir_c         = 4'h8;
    localparam logic [3:0] exit1_ir_c         = 4'h9;
    localparam logic [3:0] shift_ir_c         = 4'hA;
    localparam logic [3:0] pause_ir_c         = 4'hB;
    localparam logic [3:0] run_test_idle_c    = 4'hC;
    localparam logic [3:0] update_ir_c        = 4'hD;
    localparam logic [3:0] capture_ir_c       = 4'hE;
    localparam logic [3:0] test_logic_reset_c = 4'hF;

`ifdef IR_PARITY_EN
    localparam int SR_LEN = IR_LEN + 1;
`else
    localparam int SR_LEN = IR_LEN;
`endif
    localparam int EXP_LEN = SR_LEN;
    localparam int CNT_W   = $clog2(IR_LEN + 2) + 1;

    localparam logic [NUM_INSTR-1:0] RST_ONEHOT = NUM_INSTR'(1) << RST_INSTR;
    localparam logic [IR_LEN-1:0]    RST_OPCODE = OPCODES[RST_INSTR*IR_LEN +: IR_LEN];

    if (IR_LEN < 2) begin : g_bad_len
        $error("jtag_ir_param: IR_LEN must be at least 2");
    end
    if (RST_INSTR < 0 || RST_INSTR >= NUM_INSTR) begin : g_bad_rst
        $error("jtag_ir_param: RST_INSTR out of range");
    end

    logic [SR_LEN-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_INSTR-1:0] instr_q, instr_d;
    logic [IR_LEN-1:0]    ir_value_q, ir_value_d;
    logic                 unk_op_q, unk_op_d;
    logic                 len_err_q, len_err_d;
`ifdef IR_PARITY_EN
    logic                 par_err_q, par_err_d;
`endif

    logic [IR_LEN-1:0]    cap_base;
    logic [SR_LEN-1:0]    cap_val;
    logic [IR_LEN-1:0]    opcode;
    logic                 dec_hit;
    logic [NUM_INSTR-1:0] dec_onehot;
    logic                 par_ok;

    // Capture pattern: status in the upper bits, fixed 01 in the two LSBs
    if (IR_LEN > 2) begin : g_cap_status
        assign cap_base = {bus.status_i, 2'b01};
    end else begin : g_cap_fixed
        assign cap_base = 2'b01;
    end

`ifdef IR_PARITY_EN
    assign cap_val = {1'b1, cap_base};
    assign par_ok  = ^sr_q;
`else
    assign cap_val = cap_base;
    assign par_ok  = 1'b1;
`endif

    assign opcode = sr_q[IR_LEN-1:0];

    // Descending scan so the lowest matching index is the one that sticks
    always_comb begin
        dec_hit    = 1'b0;
        dec_onehot = '0;
        for (int i = NUM_INSTR - 1; i >= 0; i--) begin
            if (OPCODES[i*IR_LEN +: IR_LEN] == opcode) begin
                dec_hit    = 1'b1;
                dec_onehot = NUM_INSTR'(1) << i;
            end
        end
        if (&opcode) begin
            dec_hit    = 1'b1;
            dec_onehot = NUM_INSTR'(1);
        end
    end

    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        ir_value_d = ir_value_q;
        unk_op_d   = unk_op_q;
        len_err_d  = len_err_q;
`ifdef IR_PARITY_EN
        par_err_d  = par_err_q;
`endif
        case (bus.state)
            test_logic_reset_c: begin
                sr_d       = '0;
                cnt_d      = '0;
                instr_d    = RST_ONEHOT;
                ir_value_d = RST_OPCODE;
                unk_op_d   = 1'b0;
                len_err_d  = 1'b0;
`ifdef IR_PARITY_EN
                par_err_d  = 1'b0;
`endif
            end
            capture_ir_c: begin
                sr_d  = cap_val;
                cnt_d = '0;
`ifdef IR_PARITY_EN
                par_err_d = 1'b0;
`endif
            end
            shift_ir_c: begin
                sr_d = {bus.tdi, sr_q[SR_LEN-1:1]};
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            update_ir_c: begin
                len_err_d = (cnt_q != CNT_W'(EXP_LEN));
                if (!par_ok) begin
                    instr_d    = NUM_INSTR'(1);
                    ir_value_d = '1;
                    unk_op_d   = 1'b0;
`ifdef IR_PARITY_EN
                    par_err_d  = 1'b1;
`endif
                end else if (dec_hit) begin
                    instr_d    = dec_onehot;
                    ir_value_d = opcode;
                    unk_op_d   = 1'b0;
                end else begin
                    instr_d    = NUM_INSTR'(1);
                    ir_value_d = opcode;
                    unk_op_d   = 1'b1;
                end
            end
            exit2_dr_c, exit1_dr_c, shift_dr_c, pause_dr_c, select_ir_c,
            update_dr_c, capture_dr_c, select_dr_c, exit2_ir_c, exit1_ir_c,
            pause_ir_c, run_test_idle_c: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            instr_q    <= RST_ONEHOT;
            ir_value_q <= RST_OPCODE;
            unk_op_q   <= 1'b0;
            len_err_q  <= 1'b0;
`ifdef IR_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            ir_value_q <= ir_value_d;
            unk_op_q   <= unk_op_d;
            len_err_q  <= len_err_d;
`ifdef IR_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign bus.tdo      = sr_q[0];
    assign bus.tdo_en   = (bus.state == shift_ir_c);
    assign bus.instr    = instr_q;
    assign bus.ir_value = ir_value_q;
    assign bus.unk_op   = unk_op_q;
    assign bus.len_err  = len_err_q;
`ifdef IR_PARITY_EN
    assign bus.par_err  = par_err_q;
`else
    assign bus.par_err  = 1'b0;
`endif

endmodule
